// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised single-clock FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 8;

    // Address width that never collapses to zero bits, even for tiny depths.
    function automatic int clog2_safe(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int DEF_AW = clog2_safe(DEF_DEPTH);
    localparam int CNT_W  = DEF_AW + 1;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W registers, one synchronous write port and one asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, sticky
// error flags, synchronous flush and optional first-word-fall-through reads.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [clog2_safe(DEPTH):0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = clog2_safe(DEPTH);
    localparam int CW = AW + 1;

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push, pop;
    logic [DATA_W-1:0] mem_rdata;

    // The extra MSB on each pointer makes full and empty distinguishable.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    assign push = wr_en & ~full  & ~flush;
    assign pop  = rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        // A new error in the same cycle as clr_err wins, keeping the flag set.
        overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full  & ~flush);
        underflow_d = (underflow_q & ~clr_err) | (rd_en & empty & ~flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + CW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; masked to zero while nothing is stored.
        assign rd_data  = empty ? '0 : mem_rdata;
        assign rd_valid = ~empty;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q, rd_valid_d;

        always_comb begin
            rd_data_d  = pop ? mem_rdata : rd_data_q;
            rd_valid_d = pop;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read instance and an FWFT instance.
module tb_sync_fifo_param;

  logic clk;
  logic rst_n;

  // registered-read instance (a_*)
  logic       a_wr_en, a_rd_en, a_flush, a_clr_err;
  logic [3:0] a_wr_data, a_rd_data, a_count;
  logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

  // first-word-fall-through instance (b_*)
  logic       b_wr_en, b_rd_en, b_flush, b_clr_err;
  logic [3:0] b_wr_data, b_rd_data, b_count;
  logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

  int n_checks;
  int n_errors;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_data(a_wr_data), .rd_en(a_rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .flush(a_flush), .clr_err(a_clr_err),
    .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_param #(.DATA_W(4), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .flush(b_flush), .clr_err(b_clr_err),
    .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: apply one cycle of controls, sample 1ns after the edge
  task automatic a_op(input logic wr, input logic [3:0] wd, input logic rd, input logic clr);
    a_wr_en = wr; a_wr_data = wd; a_rd_en = rd; a_clr_err = clr;
    @(posedge clk); #1;
    a_wr_en = 1'b0; a_rd_en = 1'b0; a_clr_err = 1'b0;
  endtask

  task automatic b_op(input logic wr, input logic [3:0] wd, input logic rd, input logic fl);
    b_wr_en = wr; b_wr_data = wd; b_rd_en = rd; b_flush = fl;
    @(posedge clk); #1;
    b_wr_en = 1'b0; b_rd_en = 1'b0; b_flush = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    a_wr_en = 0; a_rd_en = 0; a_flush = 0; a_clr_err = 0; a_wr_data = '0;
    b_wr_en = 0; b_rd_en = 0; b_flush = 0; b_clr_err = 0; b_wr_data = '0;

    // 1: reset values
    #2;
    check("rst_empty",   32'(a_empty), 1);
    check("rst_ae",      32'(a_ae), 1);
    check("rst_count",   32'(a_count), 0);
    check("rst_full",    32'(a_full), 0);
    check("rst_af",      32'(a_af), 0);
    check("rst_ovf",     32'(a_ovf), 0);
    check("rst_unf",     32'(a_unf), 0);
    check("rst_rvalid",  32'(a_rd_valid), 0);
    check("rst_rdata",   32'(a_rd_data), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // 2: single push, pop two cycles later
    a_op(1, 4'hA, 0, 0);
    check("t2_count1", 32'(a_count), 1);
    check("t2_nempty", 32'(a_empty), 0);
    a_op(0, 4'h0, 0, 0);
    a_op(0, 4'h0, 1, 0);
    check("t2_rdata",  32'(a_rd_data), 32'hA);
    check("t2_rvalid", 32'(a_rd_valid), 1);
    check("t2_empty",  32'(a_empty), 1);
    a_op(0, 4'h0, 0, 0);
    check("t2_rvalid_drop", 32'(a_rd_valid), 0);
    check("t2_rdata_hold",  32'(a_rd_data), 32'hA);

    // 3: fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      a_op(1, 4'(i), 0, 0);
      exp_q.push_back(4'(i));
      check("t3_count", 32'(a_count), 32'(i + 1));
      check("t3_af",    32'(a_af),   32'((i + 1) >= 6));
      check("t3_full",  32'(a_full), 32'((i + 1) == 8));
    end
    a_op(1, 4'hF, 0, 0);
    check("t3_ovf",       32'(a_ovf), 1);
    check("t3_count_ovf", 32'(a_count), 8);
    for (int i = 0; i < 8; i++) begin
      a_op(0, 4'h0, 1, 0);
      e = exp_q.pop_front();
      check("t3_pop_data",  32'(a_rd_data), 32'(e));
      check("t3_pop_valid", 32'(a_rd_valid), 1);
      check("t3_pop_count", 32'(a_count), 32'(7 - i));
    end
    check("t3_empty",      32'(a_empty), 1);
    check("t3_ae",         32'(a_ae), 1);
    check("t3_ovf_sticky", 32'(a_ovf), 1);
    a_op(0, 4'h0, 0, 1);
    check("t3_ovf_clr", 32'(a_ovf), 0);

    // 4: underflow and clr_err priority
    a_op(0, 4'h0, 1, 0);
    check("t4_unf",    32'(a_unf), 1);
    check("t4_rvalid", 32'(a_rd_valid), 0);
    check("t4_count",  32'(a_count), 0);
    a_op(0, 4'h0, 0, 1);
    check("t4_unf_clr", 32'(a_unf), 0);
    a_op(0, 4'h0, 1, 1);
    check("t4_unf_clr_and_err", 32'(a_unf), 1);
    a_op(0, 4'h0, 0, 1);

    // 5: steady simultaneous read/write at count 3, then at full
    for (int i = 0; i < 3; i++) begin
      a_op(1, 4'(i), 0, 0);
      exp_q.push_back(4'(i));
    end
    check("t5_count3", 32'(a_count), 3);
    for (int k = 0; k < 20; k++) begin
      a_op(1, 4'(3 + k), 1, 0);
      exp_q.push_back(4'(3 + k));
      e = exp_q.pop_front();
      check("t5_rw_data",  32'(a_rd_data), 32'(e));
      check("t5_rw_count", 32'(a_count), 3);
    end
    for (int k = 0; k < 5; k++) begin
      a_op(1, 4'(23 + k), 0, 0);
      exp_q.push_back(4'(23 + k));
    end
    check("t5_full",  32'(a_full), 1);
    check("t5_count8", 32'(a_count), 8);
    a_op(1, 4'h0, 1, 0);
    e = exp_q.pop_front();
    check("t5_full_rw_count", 32'(a_count), 7);
    check("t5_full_rw_ovf",   32'(a_ovf), 1);
    check("t5_full_rw_data",  32'(a_rd_data), 32'(e));
    check("t5_full_rw_data_abs", 32'(a_rd_data), 32'h4);

    // 6: FWFT instance
    b_op(0, 4'h0, 1, 0);
    check("t6_unf", 32'(b_unf), 1);
    check("t6_unf_rvalid", 32'(b_rd_valid), 0);
    b_op(1, 4'hC, 0, 0);
    check("t6_fwft_data",  32'(b_rd_data), 32'hC);
    check("t6_fwft_valid", 32'(b_rd_valid), 1);
    b_op(0, 4'h0, 0, 0);
    check("t6_fwft_hold", 32'(b_rd_data), 32'hC);
    for (int i = 1; i <= 4; i++) b_op(1, 4'(i), 0, 0);
    check("t6_count5", 32'(b_count), 5);
    check("t6_head_still_c", 32'(b_rd_data), 32'hC);
    b_op(0, 4'h0, 1, 0);
    check("t6_advance", 32'(b_rd_data), 32'h1);
    check("t6_count4",  32'(b_count), 4);
    b_op(1, 4'h5, 0, 0);
    check("t6_count5b", 32'(b_count), 5);
    b_op(1, 4'h7, 1, 1);
    check("t6_flush_empty",  32'(b_empty), 1);
    check("t6_flush_count",  32'(b_count), 0);
    check("t6_flush_rvalid", 32'(b_rd_valid), 0);
    check("t6_flush_unf",    32'(b_unf), 1);
    check("t6_flush_ovf",    32'(b_ovf), 0);

    // reset in the middle of a push burst
    b_op(1, 4'h8, 0, 0);
    b_op(1, 4'h9, 0, 0);
    check("t6_burst_count", 32'(b_count), 2);
    b_wr_en = 1'b1; b_wr_data = 4'hA;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_count",  32'(b_count), 0);
    check("t6_rst_empty",  32'(b_empty), 1);
    check("t6_rst_ae",     32'(b_ae), 1);
    check("t6_rst_full",   32'(b_full), 0);
    check("t6_rst_rvalid", 32'(b_rd_valid), 0);
    check("t6_rst_rdata",  32'(b_rd_data), 0);
    check("t6_rst_unf",    32'(b_unf), 0);
    check("t6_rst_a_ovf",  32'(a_ovf), 0);
    check("t6_rst_a_count", 32'(a_count), 0);
    b_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_post_count",  32'(b_count), 0);
    check("t6_post_empty",  32'(b_empty), 1);
    check("t6_post_rvalid", 32'(b_rd_valid), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
